hazard_stall_ctrl: RTL and testbench

Central stall/flush scheduler for the 5-stage pipelined MIPS core (IF, ID, EX, MEM, WB). It drives the per-stage hold and bubble controls that the pipeline registers consume. It resolves load-use, HI/LO-after-mult/div, instruction-memory wait and data-memory wait hazards, plus taken-branch squashes, in one fixed priority. It owns the multiply/divide busy counter and the data-wait FSM.

---
 rtl/hazard_stall_ctrl_pkg.sv | 13 +
 rtl/hazard_stall_ctrl_md_busy_counter.sv | 35 +++
 rtl/hazard_stall_ctrl.sv | 122 ++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush scheduler.
package hazard_stall_ctrl_pkg;

    localparam int unsigned REG_W_DEFAULT = 5;

    typedef enum logic {RUN, DWAIT} ctrl_state_e;

    typedef logic [REG_W_DEFAULT-1:0] reg_idx_t;

    // $zero is never a real producer, so it never creates a load-use hazard
    localparam reg_idx_t REG_ZERO = '0;

endpackage

// File: rtl/hazard_stall_ctrl_md_busy_counter.sv
// Mult/div busy tracker: reloads on issue, counts down, flags a pending HI/LO result.
module md_busy_counter #(
    parameter int unsigned MD_LAT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic md_busy
);

    logic [7:0] md_cnt;
    logic [7:0] md_cnt_next;

    // Reload on issue, otherwise count down and hold at zero
    always_comb begin
        md_cnt_next = md_cnt;
        if (load) begin
            md_cnt_next = 8'(MD_LAT);
        end else if (md_cnt != '0) begin
            md_cnt_next = md_cnt - 8'd1;
        end
    end

    // Busy is registered from the next count so it lasts exactly MD_LAT cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_cnt  <= '0;
            md_busy <= 1'b0;
        end else begin
            md_cnt  <= md_cnt_next;
            md_busy <= (md_cnt_next != '0);
        end
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Central stall/flush scheduler for the 5-stage MIPS pipeline.
// Optional macro STALL_CNT_EN enables the saturating stall-cycle counter.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int unsigned MD_LAT = 4,
    parameter int unsigned REG_W  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_hilo_rd,
    input  logic             ex_is_load,
    input  logic [REG_W-1:0] ex_dst,
    input  logic             ex_md_start,
    input  logic             ex_br_taken,
    input  logic             imem_ready,
    input  logic             mem_req,
    input  logic             dmem_ready,
    output logic             stall_pc,
    output logic             stall_ifid,
    output logic             stall_idex,
    output logic             stall_exmem,
    output logic             flush_ifid,
    output logic             bubble_idex,
    output logic             bubble_memwb,
    output logic             md_busy,
    output logic [31:0]      stall_cycles
);

    ctrl_state_e state;
    ctrl_state_e state_next;

    logic dwait;
    logic lu;
    logic hl;

    assign dwait = mem_req & ~dmem_ready;
    assign lu    = ex_is_load & (ex_dst != REG_W'(REG_ZERO)) &
                   ((id_uses_rs & (id_rs == ex_dst)) | (id_uses_rt & (id_rt == ex_dst)));
    assign hl    = id_hilo_rd & (md_busy | ex_md_start);

    // EX only advances when not waiting on data memory
    md_busy_counter #(
        .MD_LAT (MD_LAT)
    ) u_md_busy_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (ex_md_start & ~dwait),
        .md_busy (md_busy)
    );

    // Fixed-priority stall/flush decode; all controls forced low during reset
    always_comb begin
        stall_pc     = 1'b0;
        stall_ifid   = 1'b0;
        stall_idex   = 1'b0;
        stall_exmem  = 1'b0;
        flush_ifid   = 1'b0;
        bubble_idex  = 1'b0;
        bubble_memwb = 1'b0;
        if (!rst_n) begin
            stall_pc = 1'b0;
        end else if (dwait) begin
            stall_pc     = 1'b1;
            stall_ifid   = 1'b1;
            stall_idex   = 1'b1;
            stall_exmem  = 1'b1;
            bubble_memwb = 1'b1;
        end else if (ex_br_taken) begin
            flush_ifid  = 1'b1;
            bubble_idex = 1'b1;
        end else if (lu | hl) begin
            stall_pc    = 1'b1;
            stall_ifid  = 1'b1;
            bubble_idex = 1'b1;
        end else if (!imem_ready) begin
            stall_pc   = 1'b1;
            flush_ifid = 1'b1;
        end
    end

    // Data-wait tracking state; outputs do not depend on it
    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (dwait) state_next = DWAIT;
            DWAIT:   if (dmem_ready || !mem_req) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

`ifdef STALL_CNT_EN
    logic [31:0] stall_cnt;

    // Count PC-hold cycles of any cause, saturating at all ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall_pc && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign stall_cycles = stall_cnt;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed, table-driven bench for hazard_stall_ctrl.
module tb_hazard_stall_ctrl;
    import hazard_stall_ctrl_pkg::*;

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic       hilo;
        logic       ld;
        logic [4:0] dst;
        logic       mds;
        logic       br;
        logic       imr;
        logic       mreq;
        logic       dmr;
        logic [6:0] exp;   // {stall_pc, stall_ifid, stall_idex, stall_exmem, flush_ifid, bubble_idex, bubble_memwb}
        logic       busy;
    } vec_t;

    localparam logic [6:0] E_NONE = 7'b000_0000;
    localparam logic [6:0] E_LU   = 7'b110_0010;
    localparam logic [6:0] E_BR   = 7'b000_0110;
    localparam logic [6:0] E_IMEM = 7'b100_0100;
    localparam logic [6:0] E_DW   = 7'b111_1001;

    logic        clk;
    logic        rst_n;
    logic [4:0]  id_rs, id_rt, ex_dst;
    logic        id_uses_rs, id_uses_rt, id_hilo_rd, ex_is_load, ex_md_start;
    logic        ex_br_taken, imem_ready, mem_req, dmem_ready;
    logic        stall_pc, stall_ifid, stall_idex, stall_exmem;
    logic        flush_ifid, bubble_idex, bubble_memwb, md_busy;
    logic [31:0] stall_cycles;

    int unsigned checks;
    int unsigned passes;
    int unsigned model_cnt;

    hazard_stall_ctrl #(
        .MD_LAT (4),
        .REG_W  (5)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rs   (id_uses_rs),
        .id_uses_rt   (id_uses_rt),
        .id_hilo_rd   (id_hilo_rd),
        .ex_is_load   (ex_is_load),
        .ex_dst       (ex_dst),
        .ex_md_start  (ex_md_start),
        .ex_br_taken  (ex_br_taken),
        .imem_ready   (imem_ready),
        .mem_req      (mem_req),
        .dmem_ready   (dmem_ready),
        .stall_pc     (stall_pc),
        .stall_ifid   (stall_ifid),
        .stall_idex   (stall_idex),
        .stall_exmem  (stall_exmem),
        .flush_ifid   (flush_ifid),
        .bubble_idex  (bubble_idex),
        .bubble_memwb (bubble_memwb),
        .md_busy      (md_busy),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                                input logic urt, input logic hilo, input logic ld,
                                input logic [4:0] dst, input logic mds, input logic br,
                                input logic imr, input logic mreq, input logic dmr,
                                input logic [6:0] exp, input logic busy);
        vec_t v;
        v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.hilo = hilo; v.ld = ld;
        v.dst = dst; v.mds = mds; v.br = br; v.imr = imr; v.mreq = mreq; v.dmr = dmr;
        v.exp = exp; v.busy = busy;
        return v;
    endfunction

    function automatic vec_t idle(input logic [6:0] exp, input logic busy);
        return mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, exp, busy);
    endfunction

    task automatic apply(input vec_t v);
        id_rs = v.rs; id_rt = v.rt; id_uses_rs = v.urs; id_uses_rt = v.urt;
        id_hilo_rd = v.hilo; ex_is_load = v.ld; ex_dst = v.dst; ex_md_start = v.mds;
        ex_br_taken = v.br; imem_ready = v.imr; mem_req = v.mreq; dmem_ready = v.dmr;
    endtask

    task automatic check_ctrl(input string name, input logic [6:0] exp);
        logic [6:0] act;
        act = {stall_pc, stall_ifid, stall_idex, stall_exmem, flush_ifid, bubble_idex, bubble_memwb};
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s ctrl: got %b expected %b", name, act, exp);
    endtask

    task automatic check_busy(input string name, input logic exp);
        checks++;
        if (md_busy === exp) passes++;
        else $display("FAIL %s md_busy: got %b expected %b", name, md_busy, exp);
    endtask

    task automatic check_cnt(input string name);
        logic [31:0] exp;
`ifdef STALL_CNT_EN
        exp = model_cnt;
`else
        exp = '0;
`endif
        checks++;
        if (stall_cycles === exp) passes++;
        else $display("FAIL %s stall_cycles: got %0d expected %0d", name, stall_cycles, exp);
    endtask

    task automatic check_state(input string name, input ctrl_state_e exp);
        checks++;
        if (dut.state === exp) passes++;
        else $display("FAIL %s state: got %0d expected %0d", name, dut.state, exp);
    endtask

    task automatic run_cycle(input vec_t v, input string name);
        @(posedge clk);
        #1;
        apply(v);
        #2;
        check_ctrl(name, v.exp);
        check_busy(name, v.busy);
        check_cnt(name);
        if (v.exp[6]) model_cnt++;
    endtask

    vec_t tbl[14];

    initial begin
        checks = 0;
        passes = 0;
        model_cnt = 0;

        tbl[0]  = idle(E_NONE, 1'b0);
        tbl[1]  = mk(5'd8, 5'd0, 1, 0, 0, 1, 5'd8, 0, 0, 1, 0, 1, E_LU,   1'b0); // load-use on rs
        tbl[2]  = idle(E_NONE, 1'b0);                                           // load moved on
        tbl[3]  = mk(5'd0, 5'd0, 1, 0, 0, 1, 5'd0, 0, 0, 1, 0, 1, E_NONE, 1'b0); // $zero dest
        tbl[4]  = mk(5'd1, 5'd9, 0, 1, 0, 1, 5'd9, 0, 0, 1, 0, 1, E_LU,   1'b0); // load-use on rt
        tbl[5]  = mk(5'd9, 5'd2, 0, 1, 0, 1, 5'd9, 0, 0, 1, 0, 1, E_NONE, 1'b0); // rs match but unused
        tbl[6]  = mk(5'd8, 5'd0, 1, 0, 0, 1, 5'd8, 0, 1, 1, 0, 1, E_BR,   1'b0); // branch beats load-use
        tbl[7]  = mk(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 0, 0, 1, E_IMEM, 1'b0); // fetch wait
        tbl[8]  = mk(5'd8, 5'd0, 1, 0, 0, 1, 5'd8, 0, 0, 0, 0, 1, E_LU,   1'b0); // load-use beats fetch wait
        tbl[9]  = mk(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 1, 0, 0, 1, E_BR,   1'b0); // branch abandons fetch
        tbl[10] = mk(5'd8, 5'd0, 1, 0, 0, 1, 5'd8, 0, 1, 0, 1, 0, E_DW,   1'b0); // data wait beats all
        tbl[11] = mk(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 1, 1, 1, E_NONE, 1'b0); // access completes
        tbl[12] = mk(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 1, 0, 0, E_NONE, 1'b0); // no req, not ready
        tbl[13] = mk(5'd0, 5'd0, 0, 0, 1, 0, 5'd0, 0, 0, 1, 0, 1, E_NONE, 1'b0); // MFHI, unit idle

        // Reset state with hazard-inducing inputs present
        rst_n = 1'b0;
        apply(mk(5'd8, 5'd0, 1, 0, 1, 1, 5'd8, 0, 0, 0, 1, 0, E_NONE, 1'b0));
        #3;
        check_ctrl("reset", E_NONE);
        check_busy("reset", 1'b0);
        check_cnt("reset");
        apply(idle(E_NONE, 1'b0));
        #9;
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            run_cycle(tbl[i], $sformatf("vec%0d", i));
        end

        // HI/LO read after a multiply: stalls exactly MD_LAT cycles
        run_cycle(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, E_NONE, 1'b0), "md_issue");
        for (int i = 0; i < 4; i++) begin
            run_cycle(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1, E_LU, 1'b1), $sformatf("hilo_wait%0d", i));
        end
        run_cycle(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1, E_NONE, 1'b0), "hilo_done");

        // Data wait with pending branch and frozen mult issue
        for (int i = 0; i < 3; i++) begin
            run_cycle(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, E_DW, 1'b0), $sformatf("dwait%0d", i));
            if (i > 0) check_state($sformatf("dwait%0d", i), DWAIT);
        end
        run_cycle(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, E_BR, 1'b0), "dwait_end_br");
        check_state("dwait_end_br", DWAIT);
        run_cycle(idle(E_NONE, 1'b1), "after_dwait");
        check_state("after_dwait", RUN);
        for (int i = 0; i < 3; i++) begin
            run_cycle(idle(E_NONE, 1'b1), $sformatf("md_tail%0d", i));
        end
        run_cycle(idle(E_NONE, 1'b0), "md_tail_done");

        // Two-cycle fetch wait
        run_cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, E_IMEM, 1'b0), "imem0");
        run_cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, E_IMEM, 1'b0), "imem1");
        run_cycle(idle(E_NONE, 1'b0), "imem_done");

        // Reset while the mult/div counter is at 2
        run_cycle(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, E_NONE, 1'b0), "rst_md_issue");
        for (int i = 0; i < 3; i++) begin
            run_cycle(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, E_LU, 1'b1), $sformatf("rst_md_busy%0d", i));
        end
        #1;
        rst_n = 1'b0;
        #1;
        model_cnt = 0;
        check_ctrl("mid_reset", E_NONE);
        check_busy("mid_reset", 1'b0);
        check_cnt("mid_reset");
        apply(idle(E_NONE, 1'b0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_cycle(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1, E_NONE, 1'b0), "post_reset_hilo");
        run_cycle(idle(E_NONE, 1'b0), "post_reset_idle");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
